plic_mt: RTL

Multi-target platform-level interrupt controller, the next generation of the single-target PLIC. It adds the following:
- Per-source level/edge trigger mode.
- Gateways that forward one request at a time.
- Proper claim (read) / complete (write) semantics, with per-target claim registers.
- A registered per-target interrupt ID output.

It sits between peripheral IRQ lines and the core(s), and is configured over the existing cfg_* slave bus.

---
 rtl/plic_mt.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/plic_mt.sv
// Multi-target PLIC: per-source level/edge gateways, per-target priority arbitration with
// registered outputs, and a two-state cfg bus that implements claim/complete.
module plic_mt #(
    parameter int unsigned NUM_SOURCES = 32,
    parameter int unsigned NUM_TARGETS = 2,
    parameter int unsigned PRIO_BITS   = 3,
    parameter int unsigned ID_W        = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SOURCES-1:0]      irq_sources_i,
    output logic [NUM_TARGETS-1:0]      irq_o,
    output logic [NUM_TARGETS*ID_W-1:0] irq_id_o,
    input  logic                        cfg_en,
    input  logic                        cfg_we,
    input  logic [31:0]                 cfg_addr,
    input  logic [31:0]                 cfg_wdata,
    output logic [31:0]                 cfg_rdata,
    output logic                        cfg_ready
);
    typedef enum logic {StIdle, StAccess} state_e;

    state_e                 state_q;
    logic [31:0]            addr_q;
    logic [31:0]            wdata_q;
    logic                   we_q;

    logic [NUM_SOURCES-1:0] sync0_q, sync1_q, sync1_prev_q;
    logic [NUM_SOURCES-1:0] pending_q, pending_d;
    logic [NUM_SOURCES-1:0] in_service_q, in_service_d;
    logic [NUM_SOURCES-1:0] deferred_q, deferred_d;
    logic [NUM_SOURCES-1:0] mode_q;
    logic [PRIO_BITS-1:0]   prio_q      [NUM_SOURCES];
    logic [NUM_SOURCES-1:0] enable_q    [NUM_TARGETS];
    logic [PRIO_BITS-1:0]   threshold_q [NUM_TARGETS];

    logic [ID_W-1:0]        best_id     [NUM_TARGETS];
    logic [PRIO_BITS-1:0]   best_prio   [NUM_TARGETS];
    logic [NUM_SOURCES-1:0] rise, level_pend;
    logic [NUM_TARGETS-1:0] claim_sel;
    logic [31:0]            rdata;
    logic                   access;

    assign access     = (state_q == StAccess);
    assign cfg_ready  = access;
    assign cfg_rdata  = (access && !we_q) ? rdata : '0;
    assign rise       = sync1_q & ~sync1_prev_q;
    assign level_pend = sync1_q & ~in_service_q;

    // Strict '>' against the running best keeps the lowest ID on priority ties.
    always_comb begin
        for (int t = 0; t < NUM_TARGETS; t++) begin
            best_id[t]   = '0;
            best_prio[t] = '0;
            for (int s = 0; s < NUM_SOURCES; s++) begin
                if (pending_q[s] && enable_q[t][s] && (prio_q[s] > threshold_q[t]) &&
                    (prio_q[s] > best_prio[t])) begin
                    best_id[t]   = ID_W'(s);
                    best_prio[t] = prio_q[s];
                end
            end
        end
    end

    always_comb begin
        for (int t = 0; t < NUM_TARGETS; t++) begin
            claim_sel[t] = (addr_q == 32'h0020_0004 + 32'(t) * 32'h1000);
        end
    end

    always_comb begin
        rdata = '0;
        for (int s = 1; s < NUM_SOURCES; s++) begin
            if (addr_q == 32'(4 * s)) rdata = 32'(prio_q[s]);
        end
        if (addr_q == 32'h0000_1000) rdata = 32'(pending_q);
        if (addr_q == 32'h0000_1004) rdata = 32'(mode_q);
        for (int t = 0; t < NUM_TARGETS; t++) begin
            if (addr_q == 32'h0000_2000 + 32'(t) * 32'h80) rdata = 32'(enable_q[t]);
            if (addr_q == 32'h0020_0000 + 32'(t) * 32'h1000) rdata = 32'(threshold_q[t]);
            if (claim_sel[t]) rdata = 32'(best_id[t]);
        end
    end

    // Gateways first, then claim/complete override, so a claim beats a same-cycle edge.
    always_comb begin
        pending_d    = pending_q;
        in_service_d = in_service_q;
        deferred_d   = deferred_q;
        for (int s = 0; s < NUM_SOURCES; s++) begin
            if (mode_q[s]) begin
                if (rise[s]) begin
                    if (in_service_q[s] || pending_q[s]) deferred_d[s] = 1'b1;
                    else                                 pending_d[s]  = 1'b1;
                end
            end else begin
                pending_d[s] = level_pend[s];
            end
        end
        for (int t = 0; t < NUM_TARGETS; t++) begin
            if (access && claim_sel[t]) begin
                for (int s = 1; s < NUM_SOURCES; s++) begin
                    if (!we_q && (best_id[t] == ID_W'(s))) begin
                        pending_d[s]    = 1'b0;
                        in_service_d[s] = 1'b1;
                    end
                    if (we_q && (wdata_q == 32'(s)) && in_service_q[s] && enable_q[t][s]) begin
                        in_service_d[s] = 1'b0;
                        if (mode_q[s] && deferred_d[s]) begin
                            pending_d[s]  = 1'b1;
                            deferred_d[s] = 1'b0;
                        end
                    end
                end
            end
        end
        pending_d[0]    = 1'b0;
        in_service_d[0] = 1'b0;
        deferred_d[0]   = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0_q      <= '0;
            sync1_q      <= '0;
            sync1_prev_q <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            deferred_q   <= '0;
            irq_o        <= '0;
            irq_id_o     <= '0;
        end else begin
            sync0_q      <= irq_sources_i;
            sync1_q      <= sync0_q;
            sync1_prev_q <= sync1_q;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            deferred_q   <= deferred_d;
            for (int t = 0; t < NUM_TARGETS; t++) begin
                irq_o[t]                  <= (best_id[t] != '0);
                irq_id_o[t*ID_W +: ID_W]  <= best_id[t];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            mode_q  <= '0;
            for (int s = 0; s < NUM_SOURCES; s++) prio_q[s] <= '0;
            for (int t = 0; t < NUM_TARGETS; t++) begin
                enable_q[t]    <= '0;
                threshold_q[t] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cfg_en) begin
                        addr_q  <= cfg_addr;
                        wdata_q <= cfg_wdata;
                        we_q    <= cfg_we;
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    if (we_q) begin
                        for (int s = 1; s < NUM_SOURCES; s++) begin
                            if (addr_q == 32'(4 * s)) prio_q[s] <= wdata_q[PRIO_BITS-1:0];
                        end
                        if (addr_q == 32'h0000_1004) mode_q <= {wdata_q[NUM_SOURCES-1:1], 1'b0};
                        for (int t = 0; t < NUM_TARGETS; t++) begin
                            if (addr_q == 32'h0000_2000 + 32'(t) * 32'h80)
                                enable_q[t] <= {wdata_q[NUM_SOURCES-1:1], 1'b0};
                            if (addr_q == 32'h0020_0000 + 32'(t) * 32'h1000)
                                threshold_q[t] <= wdata_q[PRIO_BITS-1:0];
                        end
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
